// File: rtl/axil_pkg.sv
// Shared AXI4-Lite definitions: master FSM state encoding and response codes.
package axil_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WR      = 3'd1,
    ST_WR_RESP = 3'd2,
    ST_RD_ADDR = 3'd3,
    ST_RD_DATA = 3'd4,
    ST_RSP     = 3'd5
  } state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

endpackage

// File: rtl/axil_if.sv
// AXI4-Lite bus bundle with master and slave views.
interface axil_if #(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 32
);

  logic [ADDR_WIDTH-1:0]   AWADDR;
  logic                    AWVALID;
  logic                    AWREADY;
  logic [DATA_WIDTH-1:0]   WDATA;
  logic [DATA_WIDTH/8-1:0] WSTRB;
  logic                    WVALID;
  logic                    WREADY;
  logic [1:0]              BRESP;
  logic                    BVALID;
  logic                    BREADY;
  logic [ADDR_WIDTH-1:0]   ARADDR;
  logic                    ARVALID;
  logic                    ARREADY;
  logic [DATA_WIDTH-1:0]   RDATA;
  logic [1:0]              RRESP;
  logic                    RVALID;
  logic                    RREADY;

  modport master (
    output AWADDR, AWVALID, input AWREADY,
    output WDATA, WSTRB, WVALID, input WREADY,
    input BRESP, BVALID, output BREADY,
    output ARADDR, ARVALID, input ARREADY,
    input RDATA, RRESP, RVALID, output RREADY
  );

  modport slave (
    input AWADDR, AWVALID, output AWREADY,
    input WDATA, WSTRB, WVALID, output WREADY,
    output BRESP, BVALID, input BREADY,
    input ARADDR, ARVALID, output ARREADY,
    output RDATA, RRESP, RVALID, input RREADY
  );

endinterface

// File: rtl/m_axil_master.sv
// AXI4-Lite master: turns one local command at a time into a single-beat
// AXI-Lite read or write and returns the B/R result on the response port.
// All bus VALID/READY outputs decode from the registered state, so nothing
// on the command side reaches the bus combinationally.
module m_axil_master
  import axil_pkg::*;
#(
  parameter int M_AXI_ADDR_WIDTH = 6,
  parameter int M_AXI_DATA_WIDTH = 32
) (
  input  logic                          ACLK,
  input  logic                          ARESETn,
  input  logic                          cmd_valid,
  output logic                          cmd_ready,
  input  logic                          cmd_write,
  input  logic [M_AXI_ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [M_AXI_DATA_WIDTH-1:0]   cmd_wdata,
  input  logic [M_AXI_DATA_WIDTH/8-1:0] cmd_wstrb,
  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic                          rsp_write,
  output logic [M_AXI_DATA_WIDTH-1:0]   rsp_rdata,
  output logic [1:0]                    rsp_resp,
  axil_if.master                        m_axi
);

  localparam int STRB_WIDTH = M_AXI_DATA_WIDTH / 8;

  state_t state_q, state_d;
  logic   aw_done_q, aw_done_d;
  logic   w_done_q, w_done_d;
  logic   live_q;

  logic   cmd_fire, b_fire, r_fire;
  logic   awvalid, wvalid, bready, arvalid, rready;

  logic                        write_q;
  logic [M_AXI_ADDR_WIDTH-1:0] addr_q;
  logic [M_AXI_DATA_WIDTH-1:0] wdata_q;
  logic [STRB_WIDTH-1:0]       wstrb_q;
  logic [M_AXI_DATA_WIDTH-1:0] rdata_q;
  logic [1:0]                  resp_q;

  // State register, per-channel done flags, and a flag that holds cmd_ready
  // low until the first edge after reset release.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state_q   <= ST_IDLE;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      live_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      live_q    <= 1'b1;
    end
  end

  // Next-state and output decode; AW and W complete independently and may
  // both finish in the same cycle.
  always_comb begin
    state_d   = state_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    cmd_ready = 1'b0;
    cmd_fire  = 1'b0;
    b_fire    = 1'b0;
    r_fire    = 1'b0;
    awvalid   = 1'b0;
    wvalid    = 1'b0;
    bready    = 1'b0;
    arvalid   = 1'b0;
    rready    = 1'b0;
    rsp_valid = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cmd_ready = live_q;
        if (cmd_valid && live_q) begin
          cmd_fire  = 1'b1;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          state_d   = cmd_write ? ST_WR : ST_RD_ADDR;
        end
      end
      ST_WR: begin
        awvalid   = !aw_done_q;
        wvalid    = !w_done_q;
        aw_done_d = aw_done_q | m_axi.AWREADY;
        w_done_d  = w_done_q | m_axi.WREADY;
        if (aw_done_d && w_done_d) begin
          state_d = ST_WR_RESP;
        end
      end
      ST_WR_RESP: begin
        bready = 1'b1;
        if (m_axi.BVALID) begin
          b_fire  = 1'b1;
          state_d = ST_RSP;
        end
      end
      ST_RD_ADDR: begin
        arvalid = 1'b1;
        if (m_axi.ARREADY) begin
          state_d = ST_RD_DATA;
        end
      end
      ST_RD_DATA: begin
        rready = 1'b1;
        if (m_axi.RVALID) begin
          r_fire  = 1'b1;
          state_d = ST_RSP;
        end
      end
      ST_RSP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Command fields are captured on acceptance and the bus result on the B or
  // R handshake; both stay put until the next command so payloads are stable.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      write_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      rdata_q <= '0;
      resp_q  <= RESP_OKAY;
    end else begin
      if (cmd_fire) begin
        write_q <= cmd_write;
        addr_q  <= cmd_addr;
        wdata_q <= cmd_wdata;
        wstrb_q <= cmd_wstrb;
      end
      if (b_fire) begin
        rdata_q <= '0;
        resp_q  <= m_axi.BRESP;
      end
      if (r_fire) begin
        rdata_q <= m_axi.RDATA;
        resp_q  <= m_axi.RRESP;
      end
    end
  end

  assign m_axi.AWADDR  = addr_q;
  assign m_axi.AWVALID = awvalid;
  assign m_axi.WDATA   = wdata_q;
  assign m_axi.WSTRB   = wstrb_q;
  assign m_axi.WVALID  = wvalid;
  assign m_axi.BREADY  = bready;
  assign m_axi.ARADDR  = addr_q;
  assign m_axi.ARVALID = arvalid;
  assign m_axi.RREADY  = rready;

  assign rsp_write = write_q;
  assign rsp_rdata = rdata_q;
  assign rsp_resp  = resp_q;

endmodule

// File: tb/tb_m_axil_master.sv
// Bench for m_axil_master: a configurable-latency AXI-Lite slave with a word
// memory, an expected-response queue built from command semantics, and a
// negedge compare process that checks bus payloads and responses.
module tb_m_axil_master;
  import axil_pkg::*;

  localparam int AW = 6;
  localparam int DW = 32;
  localparam int SW = DW / 8;

  logic          ACLK = 1'b0;
  logic          ARESETn = 1'b0;
  logic          cmd_valid, cmd_ready, cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic [SW-1:0] cmd_wstrb;
  logic          rsp_valid, rsp_ready, rsp_write;
  logic [DW-1:0] rsp_rdata;
  logic [1:0]    rsp_resp;

  axil_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  m_axil_master #(.M_AXI_ADDR_WIDTH(AW), .M_AXI_DATA_WIDTH(DW)) dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
    .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
    .m_axi(bus.master)
  );

  always #5 ACLK = ~ACLK;

  // ---------------- slave environment ----------------
  int         aw_delay, w_delay, b_delay, ar_delay, r_delay;
  logic [1:0] b_resp_cfg, r_resp_cfg;
  logic       stray_b, stray_r;

  int            aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt;
  logic          aw_got, w_got, b_pend, r_pend;
  logic [AW-1:0] s_awaddr;
  logic [DW-1:0] s_wdata, s_rdata;
  logic [SW-1:0] s_wstrb;
  logic [DW-1:0] slave_mem [16];

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old_w,
                                          input logic [DW-1:0] new_w,
                                          input logic [SW-1:0] strb);
    logic [DW-1:0] m;
    m = '0;
    for (int b = 0; b < SW; b++) if (strb[b]) m[b*8 +: 8] = 8'hFF;
    return (old_w & ~m) | (new_w & m);
  endfunction

  assign bus.AWREADY = bus.AWVALID && !aw_got && (aw_cnt >= aw_delay);
  assign bus.WREADY  = bus.WVALID && !w_got && (w_cnt >= w_delay);
  assign bus.BVALID  = (b_pend && (b_cnt >= b_delay)) || stray_b;
  assign bus.BRESP   = b_resp_cfg;
  assign bus.ARREADY = bus.ARVALID && (ar_cnt >= ar_delay);
  assign bus.RVALID  = (r_pend && (r_cnt >= r_delay)) || stray_r;
  assign bus.RDATA   = s_rdata;
  assign bus.RRESP   = r_resp_cfg;

  wire           aw_hs   = bus.AWVALID && bus.AWREADY;
  wire           w_hs    = bus.WVALID && bus.WREADY;
  wire           wr_both = (aw_got || aw_hs) && (w_got || w_hs);
  wire [AW-1:0]  wr_addr = aw_got ? s_awaddr : bus.AWADDR;
  wire [DW-1:0]  wr_data = w_got ? s_wdata : bus.WDATA;
  wire [SW-1:0]  wr_strb = w_got ? s_wstrb : bus.WSTRB;

  initial for (int i = 0; i < 16; i++) slave_mem[i] = '0;

  always @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      aw_cnt <= 0; w_cnt <= 0; b_cnt <= 0; ar_cnt <= 0; r_cnt <= 0;
      aw_got <= 1'b0; w_got <= 1'b0; b_pend <= 1'b0; r_pend <= 1'b0;
      s_awaddr <= '0; s_wdata <= '0; s_wstrb <= '0; s_rdata <= '0;
    end else begin
      if (aw_hs) begin
        aw_got <= 1'b1; s_awaddr <= bus.AWADDR; aw_cnt <= 0;
      end else if (bus.AWVALID) aw_cnt <= aw_cnt + 1;
      if (w_hs) begin
        w_got <= 1'b1; s_wdata <= bus.WDATA; s_wstrb <= bus.WSTRB; w_cnt <= 0;
      end else if (bus.WVALID) w_cnt <= w_cnt + 1;
      if (wr_both && !b_pend) begin
        if (b_resp_cfg == RESP_OKAY)
          slave_mem[wr_addr[AW-1:2]] <= merge(slave_mem[wr_addr[AW-1:2]], wr_data, wr_strb);
        b_pend <= 1'b1; b_cnt <= 0; aw_got <= 1'b0; w_got <= 1'b0;
      end
      if (b_pend) begin
        if (bus.BVALID && bus.BREADY) b_pend <= 1'b0;
        else b_cnt <= b_cnt + 1;
      end
      if (bus.ARVALID && bus.ARREADY) begin
        r_pend <= 1'b1; r_cnt <= 0; ar_cnt <= 0;
        s_rdata <= slave_mem[bus.ARADDR[AW-1:2]];
      end else if (bus.ARVALID) ar_cnt <= ar_cnt + 1;
      if (r_pend) begin
        if (bus.RVALID && bus.RREADY) r_pend <= 1'b0;
        else r_cnt <= r_cnt + 1;
      end
    end
  end

  // ---------------- model and scoreboard ----------------
  typedef struct {
    logic          wr;
    logic [DW-1:0] rdata;
    logic [1:0]    resp;
  } exp_t;

  exp_t          exp_q[$];
  logic [DW-1:0] model_mem [16];
  logic [AW-1:0] exp_addr;
  logic [DW-1:0] exp_wdata;
  logic [SW-1:0] exp_wstrb;

  int n_checks = 0, n_pass = 0;
  int awv_cycles, wv_cycles, bready_cycles, rspv_cycles;
  int cmd_ready_in_rsp, arv_in_rsp, rsp_count;
  logic [DW-1:0] last_rdata;
  logic [1:0]    last_resp;

  task automatic check_output(input string name, input logic [63:0] actual,
                              input logic [63:0] expected);
    n_checks++;
    if (actual === expected) n_pass++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
  endtask

  // Per-cycle compare of bus payloads and responses against the model.
  always @(negedge ACLK) begin
    if (!ARESETn) begin
      check_output("reset_outputs",
                   {bus.AWVALID, bus.WVALID, bus.ARVALID, bus.BREADY,
                    bus.RREADY, rsp_valid, cmd_ready}, 64'd0);
    end else begin
      if (bus.AWVALID) begin
        awv_cycles++;
        check_output("awaddr", bus.AWADDR, exp_addr);
      end
      if (bus.WVALID) begin
        wv_cycles++;
        check_output("wdata", bus.WDATA, exp_wdata);
        check_output("wstrb", bus.WSTRB, exp_wstrb);
      end
      if (bus.ARVALID) begin
        check_output("araddr", bus.ARADDR, exp_addr);
        if (rsp_valid) arv_in_rsp++;
      end
      if (bus.BREADY) bready_cycles++;
      if (exp_q.size() == 0) begin
        check_output("spurious_rsp", rsp_valid, 1'b0);
      end else if (rsp_valid) begin
        rspv_cycles++;
        if (cmd_ready) cmd_ready_in_rsp++;
        check_output("rsp_write", rsp_write, exp_q[0].wr);
        check_output("rsp_rdata", rsp_rdata, exp_q[0].rdata);
        check_output("rsp_resp", rsp_resp, exp_q[0].resp);
        if (rsp_ready) begin
          last_rdata = rsp_rdata;
          last_resp  = rsp_resp;
          rsp_count++;
          void'(exp_q.pop_front());
        end
      end
    end
  end

  // Issue one command, recording what its response must be.
  task automatic apply_stimulus(input logic wr, input logic [AW-1:0] addr,
                                input logic [DW-1:0] data, input logic [SW-1:0] strb,
                                input logic [1:0] resp);
    exp_t e;
    bit   ok;
    @(posedge ACLK); #1;
    e.wr = wr; e.resp = resp;
    if (wr) begin
      b_resp_cfg = resp;
      e.rdata = '0;
      if (resp == RESP_OKAY) model_mem[addr >> 2] = merge(model_mem[addr >> 2], data, strb);
    end else begin
      r_resp_cfg = resp;
      e.rdata = model_mem[addr >> 2];
    end
    exp_q.push_back(e);
    exp_addr = addr; exp_wdata = data; exp_wstrb = strb;
    cmd_write = wr; cmd_addr = addr; cmd_wdata = data; cmd_wstrb = strb;
    cmd_valid = 1'b1;
    ok = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge ACLK);
      if (cmd_ready) begin ok = 1; break; end
    end
    if (!ok) check_output("cmd_accept_timeout", cmd_ready, 1'b1);
    @(posedge ACLK); #1;
    cmd_valid = 1'b0;
  endtask

  // Wait for the response handshake; report the cycle rsp_valid first showed.
  task automatic wait_rsp(output int first_valid);
    bit done;
    first_valid = -1;
    done = 0;
    for (int i = 1; i <= 100; i++) begin
      @(negedge ACLK);
      if (rsp_valid && first_valid < 0) first_valid = i;
      if (rsp_valid && rsp_ready) begin done = 1; break; end
    end
    if (!done) check_output("rsp_timeout", rsp_valid, 1'b1);
    @(posedge ACLK); #1;
    @(negedge ACLK);
    check_output("ready_after_rsp", cmd_ready, 1'b1);
  endtask

  task automatic release_reset;
    @(posedge ACLK); #1;
    ARESETn = 1'b1;
    @(negedge ACLK);
    check_output("cmd_ready_before_edge", cmd_ready, 1'b0);
    @(negedge ACLK);
    check_output("cmd_ready_after_edge", cmd_ready, 1'b1);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int lat, cnt0;
    cmd_valid = 0; cmd_write = 0; cmd_addr = '0; cmd_wdata = '0; cmd_wstrb = '0;
    rsp_ready = 1; stray_b = 0; stray_r = 0;
    aw_delay = 0; w_delay = 0; b_delay = 1; ar_delay = 0; r_delay = 0;
    b_resp_cfg = RESP_OKAY; r_resp_cfg = RESP_OKAY;
    exp_addr = '0; exp_wdata = '0; exp_wstrb = '0;
    awv_cycles = 0; wv_cycles = 0; bready_cycles = 0; rspv_cycles = 0;
    cmd_ready_in_rsp = 0; arv_in_rsp = 0; rsp_count = 0;
    last_rdata = '0; last_resp = '0;
    for (int i = 0; i < 16; i++) model_mem[i] = '0;

    repeat (3) @(negedge ACLK);
    check_output("rst_rsp_payload", {rsp_write, rsp_rdata, rsp_resp}, 64'd0);
    release_reset();

    // Zero-wait write then read back
    apply_stimulus(1'b1, 6'h08, 32'hDEADBEEF, 4'hF, RESP_OKAY);
    wait_rsp(lat);
    check_output("write_latency", lat, 4);
    apply_stimulus(1'b0, 6'h08, '0, '0, RESP_OKAY);
    wait_rsp(lat);
    check_output("read_latency", lat, 3);
    check_output("read_deadbeef", last_rdata, 32'hDEADBEEF);

    // Partial-strobe write
    apply_stimulus(1'b1, 6'h08, 32'h12345678, 4'h3, RESP_OKAY);
    wait_rsp(lat);
    apply_stimulus(1'b0, 6'h08, '0, '0, RESP_OKAY);
    wait_rsp(lat);
    check_output("read_strobed", last_rdata, 32'hDEAD5678);

    // AWREADY held off for three cycles, WREADY immediate
    aw_delay = 3; awv_cycles = 0; wv_cycles = 0; cnt0 = rsp_count;
    apply_stimulus(1'b1, 6'h08, 32'hCAFE0001, 4'h0, RESP_OKAY);
    wait_rsp(lat);
    check_output("awvalid_cycles", awv_cycles, 4);
    check_output("wvalid_cycles", wv_cycles, 1);
    check_output("one_response", rsp_count - cnt0, 1);
    aw_delay = 0;

    // Simultaneous AW/W handshake with B delayed five cycles
    b_delay = 5; bready_cycles = 0; cnt0 = rsp_count;
    apply_stimulus(1'b1, 6'h3C, 32'hA5A50F0F, 4'hF, RESP_OKAY);
    wait_rsp(lat);
    check_output("bready_cycles", bready_cycles, 6);
    check_output("one_b_response", rsp_count - cnt0, 1);
    check_output("b_resp_okay", last_resp, 2'b00);
    b_delay = 1;

    // Response back-pressure on a read of 0x3C
    rsp_ready = 0; rspv_cycles = 0; cmd_ready_in_rsp = 0; arv_in_rsp = 0;
    apply_stimulus(1'b0, 6'h3C, '0, '0, RESP_OKAY);
    lat = 0;
    for (int i = 0; i < 50 && !rsp_valid; i++) @(negedge ACLK);
    check_output("hold_rsp_seen", rsp_valid, 1'b1);
    repeat (5) begin @(posedge ACLK); #1; end
    rsp_ready = 1;
    wait_rsp(lat);
    check_output("hold_rsp_cycles", rspv_cycles, 6);
    check_output("hold_cmd_ready", cmd_ready_in_rsp, 0);
    check_output("hold_arvalid", arv_in_rsp, 0);
    check_output("hold_rdata", last_rdata, 32'hA5A50F0F);

    // Error responses pass through and a failed write leaves memory alone
    apply_stimulus(1'b1, 6'h20, 32'h55AA55AA, 4'hF, RESP_SLVERR);
    wait_rsp(lat);
    check_output("slverr_resp", last_resp, 2'b10);
    apply_stimulus(1'b0, 6'h20, '0, '0, RESP_DECERR);
    wait_rsp(lat);
    check_output("decerr_resp", last_resp, 2'b11);
    check_output("decerr_rdata", last_rdata, 32'h0);
    b_resp_cfg = RESP_OKAY; r_resp_cfg = RESP_OKAY;

    // Stray B/R while idle must be ignored
    bready_cycles = 0; cnt0 = rsp_count;
    @(posedge ACLK); #1; stray_b = 1; stray_r = 1;
    repeat (3) begin @(posedge ACLK); #1; end
    stray_b = 0; stray_r = 0;
    repeat (2) @(negedge ACLK);
    check_output("stray_bready", bready_cycles, 0);
    check_output("stray_no_rsp", rsp_count - cnt0, 0);
    check_output("stray_cmd_ready", cmd_ready, 1'b1);

    // Reset while AWVALID is high
    aw_delay = 20; w_delay = 20;
    @(posedge ACLK); #1;
    exp_addr = 6'h10; exp_wdata = 32'h0BADF00D; exp_wstrb = 4'hF;
    cmd_write = 1; cmd_addr = 6'h10; cmd_wdata = 32'h0BADF00D; cmd_wstrb = 4'hF;
    cmd_valid = 1;
    @(negedge ACLK);
    check_output("pre_rst_cmd_ready", cmd_ready, 1'b1);
    @(posedge ACLK); #1; cmd_valid = 0;
    @(negedge ACLK);
    check_output("pre_rst_awvalid", bus.AWVALID, 1'b1);
    #2 ARESETn = 0;
    #1;
    check_output("rst_awvalid_drop", bus.AWVALID, 1'b0);
    check_output("rst_wvalid_drop", bus.WVALID, 1'b0);
    check_output("rst_rsp_valid", rsp_valid, 1'b0);
    aw_delay = 0; w_delay = 0;
    repeat (2) @(negedge ACLK);
    release_reset();
    cnt0 = rsp_count;
    repeat (4) @(negedge ACLK);
    check_output("no_stale_rsp", rsp_count - cnt0, 0);
    apply_stimulus(1'b0, 6'h10, '0, '0, RESP_OKAY);
    wait_rsp(lat);
    check_output("post_rst_read", last_rdata, 32'h0);
    check_output("queue_drained", exp_q.size(), 0);

    $display("[TB] %0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/m_axil_master.md
# m_axil_master

AXI4-Lite master (initiator) that turns single-beat commands from a local command/response port into AXI-Lite read or write transactions. It pairs with the team's `s_axil_register` style slaves as the bus driver used by benches and by on-chip controllers. It issues one transaction at a time, tracks the AW and W handshakes independently, and returns the B or R result on a response port.

## Interface
Parameters:
- M_AXI_ADDR_WIDTH, 6: AXI address width, also used for `cmd_addr`.
- M_AXI_DATA_WIDTH, 32: data width; strobe width is M_AXI_DATA_WIDTH/8.

Ports:
- ACLK  in  1  clock; every port is sampled on its rising edge.
- ARESETn  in  1  reset, asynchronous, active-low.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command accepted when high with cmd_valid.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  M_AXI_ADDR_WIDTH  byte address, forwarded unchanged.
- cmd_wdata  in  M_AXI_DATA_WIDTH  write data.
- cmd_wstrb  in  M_AXI_DATA_WIDTH/8  write strobes.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  response consumed when high with rsp_valid.
- rsp_write  out  1  echoes the cmd_write of the completed command.
- rsp_rdata  out  M_AXI_DATA_WIDTH  RDATA for reads; 0 for writes.
- rsp_resp  out  2  BRESP or RRESP.
- AWADDR out, AWVALID out, AWREADY in: write address channel.
- WDATA out, WSTRB out, WVALID out, WREADY in: write data channel.
- BRESP in [1:0], BVALID in, BREADY out: write response channel.
- ARADDR out, ARVALID out, ARREADY in: read address channel.
- RDATA in, RRESP in [1:0], RVALID in, RREADY out: read data channel.

## Operation
- FSM states: IDLE, WR (AW and/or W outstanding), WR_RESP, RD_ADDR, RD_DATA, RSP.
- IDLE: cmd_ready = 1. On cmd_valid, register the addr, data and strb fields and go to WR or RD_ADDR.
- WR: AWVALID and WVALID rise together. Each channel drops on the edge after its own handshake (aw_done/w_done flags). Go to WR_RESP once both are done, including the case where both handshakes land in the same cycle.
- WR_RESP: BREADY = 1. On BVALID, capture BRESP, set rsp_rdata = 0, go to RSP.
- RD_ADDR: ARVALID = 1 until ARREADY, then RD_DATA.
- RD_DATA: RREADY = 1. On RVALID, capture RDATA and RRESP, go to RSP.
- RSP: rsp_valid = 1 and stays high with a stable payload until rsp_ready. Then return to IDLE.
- VALIDs never depend on READYs. Payloads (AWADDR, WDATA, WSTRB, ARADDR) stay stable while the matching VALID is high.
- BREADY and RREADY are high only in WR_RESP and RD_DATA. A BVALID or RVALID seen in any other state is ignored.
- At most one transaction is outstanding. A non-OKAY response is passed through unchanged and is not retried.

## Timing
- Reset: asynchronous assertion and synchronous release. FSM goes to IDLE. Every VALID, every READY except cmd_ready, and rsp_valid = 0. cmd_ready = 1 one edge after release. Address, data and response registers = 0.
- Reset mid-transaction: the bus VALIDs drop immediately and no response is produced. The slave is expected to be reset by the same ARESETn.
- Command accepted at edge N: AW/W/AR VALID is high from cycle N+1, so there is no combinational path from cmd to bus.
- Zero-wait slave write (READYs already high, BVALID one cycle after W): handshake at N+1, BREADY from N+2, B at N+3 at the earliest, rsp_valid from N+4.
- Zero-wait slave read: AR handshake at N+1, RREADY from N+2, R at N+2 or later, rsp_valid the cycle after the R handshake.
- Back-to-back: the next command can be accepted the cycle after the rsp handshake, so the minimum spacing is one IDLE cycle.
- rsp_ready held low: the block stalls in RSP indefinitely with cmd_ready = 0.

## Structure
- Shared package `axil_pkg`:
  - FSM state encoding localparams.
  - RESP codes OKAY = 2'b00, EXOKAY = 2'b01, SLVERR = 2'b10, DECERR = 2'b11.
- No sub-module. This is a single FSM with per-channel done flags, shared by all benches that drive the register slaves.

## Test plan
- Write 0xDEADBEEF to 0x08, strb 0xF, zero-wait slave -> rsp_write = 1, rsp_resp = 00, rsp_rdata = 0. Then read 0x08 -> rsp_rdata = 0xDEADBEEF, rsp_resp = 00.
- Write 0x12345678 to 0x08 with strb 0x3 after the previous write -> read 0x08 returns 0xDEAD5678.
- Slave holds AWREADY low for 3 cycles with WREADY high -> WVALID is high for exactly 1 cycle, AWVALID is high 4 cycles with AWADDR = 0x08 stable, and exactly one response is produced.
- WREADY and AWREADY in the same cycle; B delayed 5 cycles -> BREADY is high for 6 cycles, then one response with rsp_resp = 00.
- rsp_ready low for 5 cycles after a read of 0x3C -> rsp_valid and rsp_rdata are stable for 6 cycles, cmd_ready = 0 throughout, and ARVALID stays 0.
- ARESETn pulled low while AWVALID = 1 -> AWVALID, WVALID and rsp_valid drop within the same cycle. cmd_ready = 1 one edge after release, and no stale response appears.
